// File: rtl/traffic_pkg.sv
// traffic_pkg: light encoding shared with traffic_fsm and the barrier-gate state codes
package traffic_pkg;

    localparam logic [1:0] RED    = 2'b00;
    localparam logic [1:0] GREEN  = 2'b01;
    localparam logic [1:0] YELLOW = 2'b10;

    typedef enum logic [2:0] {
        ST_CLOSED  = 3'd0,
        ST_OPENING = 3'd1,
        ST_OPEN    = 3'd2,
        ST_WARN    = 3'd3,
        ST_CLOSING = 3'd4,
        ST_FAULT   = 3'd7
    } gate_state_t;

endpackage

// File: rtl/gate_tick_counter.sv
// gate_tick_counter: 8-bit saturating tick counter with clear and hold
module gate_tick_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       clr,
    input  logic       hold,
    output logic [7:0] cnt
);

    logic [7:0] cnt_d, cnt_q;

    // clear wins over counting; saturate at 255
    always_comb begin
        cnt_d = clr ? 8'd0 : (tick && !hold && cnt_q != 8'hff) ? cnt_q + 8'd1 : cnt_q;
    end

    // counter register
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= 8'd0;
        else     cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/gate_ctrl.sv
// gate_ctrl: barrier-gate FSM driven by the traffic light phase, with limit/obstacle/timeout handling
module gate_ctrl
    import traffic_pkg::*;
#(
    parameter int WARN_TICKS   = 3,
    parameter int MOVE_TIMEOUT = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [1:0] light_state,
    input  logic       lim_open,
    input  logic       lim_closed,
    input  logic       obstacle,
    output logic       motor_up,
    output logic       motor_dn,
    output logic       buzzer,
    output logic       pass_ok,
    output logic       fault,
    output logic [2:0] gate_state
);

    localparam logic [7:0] WARN_LAST = 8'(WARN_TICKS - 1);
    localparam logic [7:0] MOVE_LAST = 8'(MOVE_TIMEOUT - 1);

    gate_state_t state_d, state_q;
    logic [7:0]  tick_cnt;
    logic        green, move_to, cnt_clr, cnt_hold;

    assign green   = light_state == GREEN;
    assign move_to = tick && tick_cnt == MOVE_LAST;

    // next-state logic; contradictory limit switches override everything except FAULT
    always_comb begin
        state_d = state_q;
        if (state_q != ST_FAULT && lim_open && lim_closed) begin
            state_d = ST_FAULT;
        end else begin
            case (state_q)
                ST_CLOSED:  state_d = green ? ST_OPENING : !lim_closed ? ST_CLOSING : ST_CLOSED;
                ST_OPENING: state_d = lim_open ? ST_OPEN : move_to ? ST_FAULT : ST_OPENING;
                ST_OPEN:    state_d = green ? ST_OPEN : ST_WARN;
                ST_WARN:    state_d = green ? ST_OPEN
                                    : (!obstacle && tick && tick_cnt == WARN_LAST) ? ST_CLOSING : ST_WARN;
                ST_CLOSING: state_d = lim_closed ? ST_CLOSED : obstacle ? ST_OPENING
                                    : move_to ? ST_FAULT : ST_CLOSING;
                ST_FAULT:   state_d = ST_FAULT;
                default:    state_d = ST_FAULT;
            endcase
        end
    end

    // counter restarts on any state change and is pinned at zero while an obstacle delays the close
    always_comb begin
        cnt_clr  = (state_d != state_q) || (state_q == ST_WARN && !green && obstacle);
        cnt_hold = state_q == ST_FAULT;
    end

    gate_tick_counter u_cnt (
        .clk  (clk),
        .rst  (rst),
        .tick (tick),
        .clr  (cnt_clr),
        .hold (cnt_hold),
        .cnt  (tick_cnt)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_CLOSED;
        else     state_q <= state_d;
    end

    assign motor_up   = state_q == ST_OPENING;
    assign motor_dn   = state_q == ST_CLOSING;
    assign buzzer     = state_q == ST_WARN || state_q == ST_CLOSING || state_q == ST_FAULT;
    assign pass_ok    = state_q == ST_OPEN;
    assign fault      = state_q == ST_FAULT;
    assign gate_state = state_q;

endmodule

// File: tb/tb_gate_ctrl.sv
// tb_gate_ctrl: directed scoreboard bench for gate_ctrl
module tb_gate_ctrl;
  logic       clk = 1'b0;
  logic       rst, tick, lim_open, lim_closed, obstacle;
  logic [1:0] light;
  logic       motor_up, motor_dn, buzzer, pass_ok, fault;
  logic [2:0] gate_state;
  localparam logic [7:0] E_CLOSED  = {3'd0, 5'b00000};
  localparam logic [7:0] E_OPENING = {3'd1, 5'b10000};
  localparam logic [7:0] E_OPEN    = {3'd2, 5'b00010};
  localparam logic [7:0] E_WARN    = {3'd3, 5'b00100};
  localparam logic [7:0] E_CLOSING = {3'd4, 5'b01100};
  localparam logic [7:0] E_FAULT   = {3'd7, 5'b00101};
  typedef struct {
    string      name;
    logic [7:0] v;
  } exp_t;
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  gate_ctrl #(.WARN_TICKS(3), .MOVE_TIMEOUT(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .light_state(light),
    .lim_open   (lim_open),
    .lim_closed (lim_closed),
    .obstacle   (obstacle),
    .motor_up   (motor_up),
    .motor_dn   (motor_dn),
    .buzzer     (buzzer),
    .pass_ok    (pass_ok),
    .fault      (fault),
    .gate_state (gate_state)
  );
  always #5 clk = ~clk;
  task automatic clk1();
    @(posedge clk);
    #1;
  endtask
  task automatic do_tick(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      clk1();
      tick = 1'b0;
    end
  endtask
  task automatic expect_st(input string n, input logic [7:0] v);
    sb.push_back('{n, v});
  endtask
  task automatic chk(input string n, input logic [7:0] v);
    logic [7:0] got;
    got = {gate_state, motor_up, motor_dn, buzzer, pass_ok, fault};
    checks++;
    if (got !== v) begin
      errors++;
      $display("FAIL %s got %b want %b", n, got, v);
    end
  endtask
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        exp_t e;
        logic [7:0] got;
        e   = sb.pop_front();
        got = {gate_state, motor_up, motor_dn, buzzer, pass_ok, fault};
        checks++;
        if (got !== e.v) begin
          errors++;
          $display("FAIL %s got %b want %b", e.name, got, e.v);
        end
      end
    end
  end
  initial begin
    rst = 1'b1; tick = 1'b0; light = 2'b00;
    lim_open = 1'b0; lim_closed = 1'b1; obstacle = 1'b0;
    repeat (5) clk1();
    chk("reset_direct", E_CLOSED);
    expect_st("reset", E_CLOSED);
    clk1();
    rst = 1'b0;
    clk1();
    expect_st("post_reset", E_CLOSED);
    do_tick(2);
    expect_st("stay_closed", E_CLOSED);
    light = 2'b01;
    clk1();
    expect_st("open_start", E_OPENING);
    lim_closed = 1'b0;
    do_tick(4);
    expect_st("opening_4t", E_OPENING);
    lim_open = 1'b1; tick = 1'b1;
    clk1();
    tick = 1'b0;
    expect_st("lim_open_wins", E_OPEN);
    clk1();
    expect_st("open_hold", E_OPEN);
    light = 2'b10;
    clk1();
    expect_st("warn_enter", E_WARN);
    lim_open = 1'b0;
    do_tick(2);
    expect_st("warn_2t", E_WARN);
    do_tick(1);
    expect_st("closing_3t", E_CLOSING);
    lim_closed = 1'b1;
    clk1();
    expect_st("closed_lim", E_CLOSED);
    light = 2'b01;
    clk1();
    lim_closed = 1'b0; lim_open = 1'b1;
    clk1();
    expect_st("reopen", E_OPEN);
    light = 2'b00;
    clk1();
    lim_open = 1'b0;
    do_tick(2);
    obstacle = 1'b1;
    do_tick(5);
    expect_st("warn_obst", E_WARN);
    obstacle = 1'b0;
    do_tick(2);
    expect_st("warn_after_obst", E_WARN);
    do_tick(1);
    expect_st("closing_after_obst", E_CLOSING);
    obstacle = 1'b1;
    clk1();
    obstacle = 1'b0;
    expect_st("reversal", E_OPENING);
    do_tick(9);
    expect_st("opening_9t", E_OPENING);
    do_tick(1);
    chk("timeout_direct", E_FAULT);
    expect_st("timeout", E_FAULT);
    light = 2'b01; clk1();
    light = 2'b00; do_tick(3);
    lim_closed = 1'b1; light = 2'b01; clk1();
    expect_st("fault_sticky", E_FAULT);
    rst = 1'b1; light = 2'b00;
    clk1();
    expect_st("fault_reset", E_CLOSED);
    rst = 1'b0;
    light = 2'b01;
    clk1();
    expect_st("open_again", E_OPENING);
    rst = 1'b1;
    clk1();
    expect_st("reset_midstroke", E_CLOSED);
    rst = 1'b0;
    clk1();
    lim_closed = 1'b0; lim_open = 1'b1;
    clk1();
    expect_st("open_for_sensor", E_OPEN);
    lim_closed = 1'b1;
    clk1();
    expect_st("both_limits", E_FAULT);
    rst = 1'b1; lim_open = 1'b0; light = 2'b00;
    clk1();
    rst = 1'b0;
    clk1();
    expect_st("closed_again", E_CLOSED);
    lim_closed = 1'b0;
    clk1();
    expect_st("drift_close", E_CLOSING);
    lim_closed = 1'b1;
    clk1();
    expect_st("drift_closed", E_CLOSED);
    light = 2'b01;
    clk1();
    lim_closed = 1'b0; lim_open = 1'b1;
    clk1();
    expect_st("open_for_11", E_OPEN);
    light = 2'b11;
    clk1();
    expect_st("light_11_warn", E_WARN);
    clk1();
    clk1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
